// File: rtl/pot_scan_ctrl.sv
// -----------------------------------------------------------------------------
// pot_scan_ctrl
//   Round-robin scheduler for the shared ADC128S A2D. For each of the six slide
//   pots (LP, B1, B2, B3, HP, VOLUME) it issues a 16-bit command frame and a
//   16-bit read frame through the SPI master. It then latches the 12-bit result
//   into that pot's register. After every read it waits SCAN_GAP idle clocks
//   before starting the next channel.
//
//   Optional feature macro: POT_SMOOTH_EN
//     When defined, each read after a channel's first sample loads
//     (old + new) >> 1 instead of the raw sample.
//
// Parameters
//   SCAN_GAP    idle clocks between one read and the next command (1..65535)
//
// Ports
//   clk         system clock
//   RST_n       asynchronous active-low reset
//   spi_done    SPI master transaction-complete pulse
//   spi_resp    SPI receive word, valid with spi_done
//   spi_strt    one-cycle transaction start request (registered)
//   spi_cmd     word to transmit, held from spi_strt until spi_done
//   LP_gain, B1_gain, B2_gain, B3_gain, HP_gain, VOLUME
//               latest 12-bit pot values
//   scan_valid  sticky flag, set once all six channels have been read
// -----------------------------------------------------------------------------
module pot_scan_ctrl #(
  parameter int SCAN_GAP = 1024
) (
  input  logic        clk,
  input  logic        RST_n,
  input  logic        spi_done,
  input  logic [15:0] spi_resp,
  output logic        spi_strt,
  output logic [15:0] spi_cmd,
  output logic [11:0] LP_gain,
  output logic [11:0] B1_gain,
  output logic [11:0] B2_gain,
  output logic [11:0] B3_gain,
  output logic [11:0] HP_gain,
  output logic [11:0] VOLUME,
  output logic        scan_valid
);

  localparam logic [15:0] GAP_LEN  = 16'(SCAN_GAP);
  localparam logic [2:0]  LAST_IDX = 3'd5;

  typedef enum logic [2:0] {
    ST_GAP      = 3'd0,
    ST_CMD      = 3'd1,
    ST_WAIT_CMD = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_RD       = 3'd4,
    ST_WAIT_RD  = 3'd5
  } state_t;

  state_t      state_r;
  state_t      nxt_state_s;
  logic [15:0] gap_cnt_r;
  logic [2:0]  idx_r;
  logic        cap_s;
  logic        strt_nxt_s;
  logic [11:0] new_val_s;
  logic [11:0] gain_r [0:5];
  logic        spi_strt_r;
  logic [15:0] spi_cmd_r;
  logic        scan_valid_r;
  logic        unused_resp_hi_s;

`ifdef POT_SMOOTH_EN
  logic [5:0]  seen_r;
`endif

  // Scan index to ADC channel number.
  function automatic logic [2:0] adc_chnl(input logic [2:0] idx);
    case (idx)
      3'd0:    adc_chnl = 3'd1;
      3'd1:    adc_chnl = 3'd0;
      3'd2:    adc_chnl = 3'd4;
      3'd3:    adc_chnl = 3'd2;
      3'd4:    adc_chnl = 3'd3;
      3'd5:    adc_chnl = 3'd7;
      default: adc_chnl = 3'd1;
    endcase
  endfunction

  // ADC128S control word; the same word is sent on the read frame.
  function automatic logic [15:0] cmd_word(input logic [2:0] chnl);
    cmd_word = {2'b00, chnl, 11'h000};
  endfunction

  // Two-sample average, summed at 13 bits so the carry is not lost.
  function automatic logic [11:0] smooth(input logic [11:0] old_v, input logic [11:0] new_v);
    logic [12:0] sum;
    sum    = {1'b0, old_v} + {1'b0, new_v};
    smooth = sum[12:1];
  endfunction

  // Upper response nibble carries no data.
  assign unused_resp_hi_s = ^spi_resp[15:12];

  // Next-state decode and capture strobe.
  always_comb begin
    nxt_state_s = state_r;
    cap_s       = 1'b0;
    case (state_r)
      ST_GAP: begin
        if (gap_cnt_r == GAP_LEN) begin
          nxt_state_s = ST_CMD;
        end else begin
          nxt_state_s = ST_GAP;
        end
      end
      ST_CMD:      nxt_state_s = ST_WAIT_CMD;
      ST_WAIT_CMD: begin
        if (spi_done) begin
          nxt_state_s = ST_SETTLE;
        end else begin
          nxt_state_s = ST_WAIT_CMD;
        end
      end
      ST_SETTLE:   nxt_state_s = ST_RD;
      ST_RD:       nxt_state_s = ST_WAIT_RD;
      ST_WAIT_RD: begin
        if (spi_done) begin
          nxt_state_s = ST_GAP;
          cap_s       = 1'b1;
        end else begin
          nxt_state_s = ST_WAIT_RD;
        end
      end
      default:     nxt_state_s = ST_GAP;
    endcase
  end

  // spi_strt is registered, so it is launched from the next-state decode to
  // line up with the CMD and RD states.
  assign strt_nxt_s = (nxt_state_s == ST_CMD) || (nxt_state_s == ST_RD);

  // Value to load into the current channel register.
  always_comb begin
    new_val_s = spi_resp[11:0];
`ifdef POT_SMOOTH_EN
    if (seen_r[idx_r]) begin
      new_val_s = smooth(gain_r[idx_r], spi_resp[11:0]);
    end else begin
      new_val_s = spi_resp[11:0];
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_r <= ST_GAP;
    end else begin
      state_r <= nxt_state_s;
    end
  end

  // Gap counter. Out of reset it starts at 0, so the release cycle itself is
  // part of the first gap and the first strt lands SCAN_GAP+1 clocks out.
  // After a read it restarts at 1, so the gap between channels is exactly
  // SCAN_GAP. This gives a period of SCAN_GAP + 3 + 2*T_spi.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      gap_cnt_r <= 16'd0;
    end else if (cap_s) begin
      gap_cnt_r <= 16'd1;
    end else if ((state_r == ST_GAP) && (nxt_state_s == ST_GAP)) begin
      gap_cnt_r <= gap_cnt_r + 16'd1;
    end else begin
      gap_cnt_r <= 16'd0;
    end
  end

  // Channel index, advanced when a read result is captured.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      idx_r <= 3'd0;
    end else if (cap_s) begin
      idx_r <= (idx_r == LAST_IDX) ? 3'd0 : idx_r + 3'd1;
    end else begin
      idx_r <= idx_r;
    end
  end

  // SPI request and command word, held until the next request.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      spi_strt_r <= 1'b0;
      spi_cmd_r  <= 16'h0000;
    end else begin
      spi_strt_r <= strt_nxt_s;
      if (strt_nxt_s) begin
        spi_cmd_r <= cmd_word(adc_chnl(idx_r));
      end else begin
        spi_cmd_r <= spi_cmd_r;
      end
    end
  end

  // Channel result registers; only the addressed one loads.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < 6; i++) begin
        gain_r[i] <= 12'h000;
      end
    end else if (cap_s) begin
      gain_r[idx_r] <= new_val_s;
    end else begin
      for (int i = 0; i < 6; i++) begin
        gain_r[i] <= gain_r[i];
      end
    end
  end

  // Sticky scan-complete flag, set by the first VOLUME write.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      scan_valid_r <= 1'b0;
    end else if (cap_s && (idx_r == LAST_IDX)) begin
      scan_valid_r <= 1'b1;
    end else begin
      scan_valid_r <= scan_valid_r;
    end
  end

`ifdef POT_SMOOTH_EN
  // Per-channel flag: first sample after reset loads raw.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      seen_r <= 6'b000000;
    end else if (cap_s) begin
      seen_r[idx_r] <= 1'b1;
    end else begin
      seen_r <= seen_r;
    end
  end
`endif

  assign spi_strt   = spi_strt_r;
  assign spi_cmd    = spi_cmd_r;
  assign LP_gain    = gain_r[0];
  assign B1_gain    = gain_r[1];
  assign B2_gain    = gain_r[2];
  assign B3_gain    = gain_r[3];
  assign HP_gain    = gain_r[4];
  assign VOLUME     = gain_r[5];
  assign scan_valid = scan_valid_r;

endmodule

// File: tb/tb_pot_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pot_scan_ctrl
//   Bench for pot_scan_ctrl with SCAN_GAP = 8. An inline SPI stub answers each
//   request after a chosen number of clocks. A transaction-level model tracks
//   the expected channel order, register contents and scan_valid.
// -----------------------------------------------------------------------------
module tb_pot_scan_ctrl;

  localparam int GAP = 8;

  logic        clk = 1'b0;
  logic        RST_n = 1'b0;
  logic        spi_done = 1'b0;
  logic [15:0] spi_resp = 16'h0000;
  logic        spi_strt;
  logic [15:0] spi_cmd;
  logic [11:0] LP_gain, B1_gain, B2_gain, B3_gain, HP_gain, VOLUME;
  logic        scan_valid;

  pot_scan_ctrl #(.SCAN_GAP(GAP)) dut (
    .clk       (clk),
    .RST_n     (RST_n),
    .spi_done  (spi_done),
    .spi_resp  (spi_resp),
    .spi_strt  (spi_strt),
    .spi_cmd   (spi_cmd),
    .LP_gain   (LP_gain),
    .B1_gain   (B1_gain),
    .B2_gain   (B2_gain),
    .B3_gain   (B3_gain),
    .HP_gain   (HP_gain),
    .VOLUME    (VOLUME),
    .scan_valid(scan_valid)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  bit abort = 1'b0;

  // Reference model state
  int chmap [6] = '{1, 0, 4, 2, 3, 7};
  int m_reg [6];
  bit m_seen [6];
  bit m_valid;
  int m_idx;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [11:0] dut_reg(input int i);
    case (i)
      0:       return LP_gain;
      1:       return B1_gain;
      2:       return B2_gain;
      3:       return B3_gain;
      4:       return HP_gain;
      default: return VOLUME;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_reg[i]  = 0;
      m_seen[i] = 1'b0;
    end
    m_valid = 1'b0;
    m_idx   = 0;
  endtask

  task automatic model_read(input logic [15:0] resp);
    int v;
    v = int'(resp) % 4096;
`ifdef POT_SMOOTH_EN
    if (m_seen[m_idx]) m_reg[m_idx] = (m_reg[m_idx] + v) / 2;
    else               m_reg[m_idx] = v;
`else
    m_reg[m_idx] = v;
`endif
    m_seen[m_idx] = 1'b1;
    if (m_idx == 5) m_valid = 1'b1;
    m_idx = (m_idx + 1) % 6;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("%s_reg%0d", tag, i), 32'(dut_reg(i)), 32'(m_reg[i]));
    end
    check_val($sformatf("%s_scan_valid", tag), 32'(scan_valid), 32'(m_valid));
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_strt"}, 32'(spi_strt), 32'd0);
    check_val({tag, "_cmd"},  32'(spi_cmd),  32'd0);
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("%s_reg%0d", tag, i), 32'(dut_reg(i)), 32'd0);
    end
    check_val({tag, "_scan_valid"}, 32'(scan_valid), 32'd0);
  endtask

  // One channel: command frame then read frame, answered after t clocks.
  // inject_at: clock offset after the previous read done at which a stray
  // spi_done is pulsed during the gap (-1 = none).
  // rst_at: clock inside the read wait at which reset is pulsed (-1 = none).
  task automatic chan_frame(input logic [15:0] resp, input int t,
                            input int inject_at, input int rst_at);
    logic [15:0] cmd_exp;
    int          s_cyc;
    bit          ok;
    if (abort) return;
    cmd_exp = 16'(chmap[m_idx] * 2048);

    while (spi_strt !== 1'b1 && (cyc - last_done_cyc) < 3000) begin
      if ((cyc - last_done_cyc) == inject_at) begin
        spi_done = 1'b1;
        spi_resp = 16'($urandom);
        tick();
        spi_done = 1'b0;
        check_regs("gap_done");
      end else begin
        tick();
      end
    end
    check_val("cmd_strt_latency", 32'(cyc - last_done_cyc), 32'(GAP + 1));
    if (spi_strt !== 1'b1) begin
      abort = 1'b1;
      return;
    end
    check_val("cmd_word", 32'(spi_cmd), 32'(cmd_exp));

    s_cyc = cyc;
    ok    = 1'b1;
    for (int i = 0; i < t; i++) begin
      tick();
      if (spi_strt !== 1'b0 || spi_cmd !== cmd_exp) ok = 1'b0;
    end
    check_val("cmd_hold", 32'(ok), 32'd1);
    spi_done = 1'b1;
    spi_resp = 16'($urandom);
    tick();
    spi_done = 1'b0;

    while (spi_strt !== 1'b1 && (cyc - s_cyc - t) < 10) tick();
    check_val("settle_gap", 32'(cyc - s_cyc - t), 32'd2);
    if (spi_strt !== 1'b1) begin
      abort = 1'b1;
      return;
    end
    check_val("rd_word", 32'(spi_cmd), 32'(cmd_exp));

    ok = 1'b1;
    for (int i = 0; i < t; i++) begin
      tick();
      if (i == rst_at) begin
        RST_n = 1'b0;
        #1;
        check_reset("rst_async");
        spi_done = 1'b1;
        spi_resp = 16'hFABC;
        tick();
        spi_done = 1'b0;
        check_reset("rst_held");
        tick();
        RST_n = 1'b1;
        model_reset();
        last_done_cyc = cyc;
        return;
      end
      if (spi_strt !== 1'b0 || spi_cmd !== cmd_exp) ok = 1'b0;
    end
    check_val("rd_hold", 32'(ok), 32'd1);

    spi_done = 1'b1;
    spi_resp = resp;
    last_done_cyc = cyc;
    model_read(resp);
    tick();
    spi_done = 1'b0;
    check_regs("after_rd");
  endtask

  initial begin
    int inj;
    model_reset();
    repeat (3) tick();
    check_reset("por");

    RST_n = 1'b1;
    last_done_cyc = cyc;

    // LP first, with junk in the upper nibble
    chan_frame(16'hF123, 40, -1, -1);
    check_val("lp_raw", 32'(LP_gain), 32'h123);

    // Rest of the first pass, a stray done in the gap before B2
    for (int k = 1; k < 6; k++) begin
      chan_frame(16'((k + 1) * 16'h111), int'($urandom_range(2, 30)), (k == 2) ? 3 : -1, -1);
    end
    check_val("scan_valid_first", 32'(scan_valid), 32'd1);

    // Wrap back to LP (ch1)
    chan_frame(16'h0111, 12, -1, -1);

    // Randomized channels
    for (int k = 0; k < 12; k++) begin
      inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, GAP - 1)) : -1;
      chan_frame(16'($urandom), int'($urandom_range(2, 30)), inj, -1);
    end

    // Reset during B3's read wait
    while (m_idx != 3 && !abort) chan_frame(16'($urandom), 6, -1, -1);
    chan_frame(16'h0ABC, 20, -1, 5);

    // Post-reset: LP raw, then LP again after a full pass
    chan_frame(16'h0400, 10, 4, -1);
    check_val("lp_first", 32'(LP_gain), 32'h400);
    for (int k = 1; k < 6; k++) begin
      chan_frame(16'($urandom), int'($urandom_range(2, 20)), -1, -1);
    end
    chan_frame(16'h0800, 10, -1, -1);
`ifdef POT_SMOOTH_EN
    check_val("lp_second", 32'(LP_gain), 32'h600);
`else
    check_val("lp_second", 32'(LP_gain), 32'h800);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pot_scan_ctrl.md
# pot_scan_ctrl

Scheduler for the shared A2D resource (ADC128S over SPI) in the Equalizer. It round-robins the six slide-pot channels (LP, B1, B2, B3, HP, VOLUME), issuing one 16-bit SPI command transaction and one 16-bit read transaction per channel. Each result is latched into that channel's 12-bit register for the filter-gain and volume datapath. It sits between the SPI master and the band-scaling logic, and is the only requester of the SPI master.

## Interface
- SCAN_GAP, default 1024: idle clocks between the end of one channel's read and the next channel's command; legal range 1..65535.
- clk  in  1  system clock (50 MHz).
- RST_n  in  1  asynchronous active-low reset.
- spi_done  in  1  one-cycle pulse from the SPI master: transaction complete.
- spi_resp  in  16  data shifted in during the last transaction; valid when spi_done is high.
- spi_strt  out  1  one-cycle request to start a 16-bit SPI transaction.
- spi_cmd  out  16  word to send; held stable from spi_strt until spi_done.
- LP_gain, B1_gain, B2_gain, B3_gain, HP_gain  out  12 each  latest pot values.
- VOLUME  out  12  latest volume pot value.
- scan_valid  out  1  set after the first complete pass over all six channels; sticky until reset.

## Operation
- Channel sequence, index 0..5 mapped to ADC channel:
  - 0 → ch1 → LP_gain
  - 1 → ch0 → B1_gain
  - 2 → ch4 → B2_gain
  - 3 → ch2 → B3_gain
  - 4 → ch3 → HP_gain
  - 5 → ch7 → VOLUME
- Index wraps 5 → 0.
- Command word: {2'b00, chnl[2:0], 11'h000}. Read word: same value (don't-care for the ADC, but fixed for determinism).
- States:
  - GAP: count SCAN_GAP clocks, then go to CMD.
  - CMD: pulse spi_strt with the command word, go to WAIT_CMD.
  - WAIT_CMD: on spi_done go to SETTLE.
  - SETTLE: one idle cycle so SS_n deasserts between frames, then go to RD.
  - RD: pulse spi_strt, go to WAIT_RD.
  - WAIT_RD: on spi_done capture spi_resp[11:0] into the current channel register, advance the index, and go to GAP.
- After reset the state machine is in GAP with index 0 and the counter cleared.
- spi_done received in any state other than WAIT_CMD or WAIT_RD: ignored.
- spi_resp[15:12] are discarded.
- scan_valid sets in the same cycle that index 5 is written on the first pass.
- Reset asserted mid-transaction: all state clears immediately. spi_strt is low while RST_n is low. The partial result is never written.

## Timing
- Reset values: spi_strt 0, spi_cmd 16'h0000, all six channel registers 12'h000, scan_valid 0.
- First spi_strt occurs SCAN_GAP+1 clocks after RST_n deasserts.
- Channel register updates on the clock edge following the spi_done of the read frame (1-cycle latency). The other five registers hold.
- Exactly one cycle of SETTLE between the command done and the read strt.
- Channel period = SCAN_GAP + 3 + 2·T_spi clocks, where T_spi is the SPI master's strt-to-done time.
- Full scan = 6 channel periods.
- spi_strt is never asserted while a transaction is outstanding.

## Configuration
- POT_SMOOTH_EN:
  - Defined: on each read after the first sample of a channel, the register loads (old + new) >> 1, computed at 13 bits and truncated to 12. The first sample of each channel after reset loads raw, tracked by one flag per channel.
  - Undefined: the register loads the raw spi_resp[11:0].
  - No other behaviour changes between builds.

## Test plan
- Reset release with SCAN_GAP=8 and a stub SPI responder (T_spi=40): first spi_strt at clock 9, spi_cmd=16'h0800 (ch1). The read strt follows the done after exactly one idle cycle.
- Stub returns 16'hF123 on LP's read frame → LP_gain=12'h123 one clock after spi_done; other registers stay 12'h000.
- Run 6 channels with responses 0x111..0x666 → LP=111, B1=222, B2=333, B3=444, HP=555, VOLUME=666. scan_valid rises with the VOLUME write. The next command is ch1 again (wrap).
- Inject spi_done while in GAP → no register changes and no state advance.
- Assert RST_n low during WAIT_RD of B3, then release → all outputs return to reset values, and the next command is ch1 after SCAN_GAP+1 clocks.
- POT_SMOOTH_EN defined: LP reads 12'h400 then 12'h800 → LP_gain 12'h400 then 12'h600. Without the macro, the second value is 12'h800.
